// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//   Iterative RV32M multiply/divide unit together with its sequencing FSM.
//   Handles MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU. Each operation
//   takes one shift-add (multiply) or shift-subtract (divide) step per cycle.
//   The work is done on operand magnitudes, and the sign is fixed up at the
//   end. Divide-by-zero and signed overflow are resolved at accept time
//   without iterating.
//
// Ports
//   clk      in   1     system clock, rising edge
//   rst_n    in   1     asynchronous active-low reset
//   start    in   1     operation request, sampled only in IDLE or DONE
//   funct3   in   3     RV32M operation select
//   op_a     in   XLEN  rs1 value (multiplicand / dividend)
//   op_b     in   XLEN  rs2 value (multiplier / divisor)
//   kill     in   1     synchronous flush, aborts the current operation
//   busy     out  1     high while iterating (CALC) or fixing signs (FIX)
//   done     out  1     one-cycle pulse, result valid this cycle
//   result   out  XLEN  registered result, held until overwritten
// ---------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_magA;
  logic [XLEN-1:0]   r_magB;
  logic              r_negProd;
  logic              r_negRem;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_isDiv;
  logic              w_signedA;
  logic              w_signedB;
  logic              w_negA;
  logic              w_negB;
  logic [XLEN-1:0]   w_magA;
  logic [XLEN-1:0]   w_magB;
  logic [XLEN-1:0]   w_minNeg;
  logic              w_divZero;
  logic              w_overflow;
  logic              w_special;
  logic [XLEN-1:0]   w_specialVal;
  logic [XLEN:0]     w_addend;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_quoFix;
  logic [XLEN-1:0]   w_remFix;
  logic [XLEN-1:0]   w_fixVal;

  // Operand decode at accept time. MUL is treated as unsigned because its
  // low half does not depend on signedness, so it never needs a fix-up.
  always_comb begin
    w_isDiv   = funct3[2];
    w_signedA = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    w_signedB = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                (funct3 == 3'b110);
    w_negA    = w_signedA & op_a[XLEN-1];
    w_negB    = w_signedB & op_b[XLEN-1];
    w_magA    = w_negA ? -op_a : op_a;
    w_magB    = w_negB ? -op_b : op_b;
    w_minNeg  = {1'b1, {(XLEN-1){1'b0}}};
    w_divZero = (op_b == '0);
    w_overflow = (op_a == w_minNeg) && (op_b == '1);
    // Overflow only matters for the signed DIV/REM encodings (funct3[0]=0).
    w_special = w_isDiv & (w_divZero | (w_overflow & ~funct3[0]));
    if (w_divZero) begin
      w_specialVal = funct3[1] ? op_a : '1;
    end else begin
      w_specialVal = funct3[1] ? '0 : w_minNeg;
    end
  end

  // Accept only when the unit is idle or presenting a result. A coincident
  // kill always wins over start.
  assign w_accept = start & ~kill & ((r_state == IDLE) || (r_state == DONE));

  // One iteration step. The multiply adds the multiplicand into the upper
  // half and shifts the whole product right, consuming one multiplier bit.
  // The divide shifts one dividend bit into the partial remainder and keeps
  // the subtraction only if it does not go negative (restoring division).
  always_comb begin
    w_addend = r_prod[0] ? {1'b0, r_magA} : '0;
    w_sum    = {1'b0, r_prod[2*XLEN-1:XLEN]} + w_addend;
    w_shift  = {r_rem, r_quo[XLEN-1]};
    w_diff   = w_shift - {1'b0, r_magB};
  end

  // Sign fix-up and result selection.
  always_comb begin
    w_prodFix = r_negProd ? -r_prod : r_prod;
    w_quoFix  = r_negProd ? -r_quo  : r_quo;
    w_remFix  = r_negRem  ? -r_rem  : r_rem;
    case (r_funct3)
      3'b000:                 w_fixVal = w_prodFix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fixVal = w_prodFix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fixVal = w_quoFix;
      default:                w_fixVal = w_remFix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Special cases go straight to DONE, and kill returns
  // to IDLE from anywhere.
  always_comb begin
    w_nextState = r_state;
    if (kill) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_nextState = w_special ? DONE : CALC;
          end else begin
            w_nextState = IDLE;
          end
        end
        CALC: begin
          if (r_cnt == CW'(XLEN - 1)) begin
            w_nextState = FIX;
          end
        end
        FIX:     w_nextState = DONE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Datapath registers. Latched operand copies are the only values used
  // after accept, so the inputs are free to change afterwards. The result
  // register changes only on a special-case accept or at the end of FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_funct3  <= '0;
      r_magA    <= '0;
      r_magB    <= '0;
      r_negProd <= 1'b0;
      r_negRem  <= 1'b0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_funct3  <= funct3;
      r_magA    <= w_magA;
      r_magB    <= w_magB;
      r_negProd <= w_negA ^ w_negB;
      r_negRem  <= w_negA;
      r_prod    <= {{XLEN{1'b0}}, w_magB};
      r_rem     <= '0;
      r_quo     <= w_magA;
      if (w_special) begin
        r_result <= w_specialVal;
      end
    end else if (!kill && (r_state == CALC)) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_funct3[2]) begin
        r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
        r_rem <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      end else begin
        r_prod <= {w_sum, r_prod[XLEN-1:1]};
      end
    end else if (!kill && (r_state == FIX)) begin
      r_result <= w_fixVal;
    end
  end

  assign busy   = (r_state == CALC) || (r_state == FIX);
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule
